// File: rtl/ram_responder.sv
// Memory-side responder for the raddr_0/waddr_0 RAM port bundle: read-valid handshake,
// configurable read pipeline, write-first forwarding, debug preload port and status flags.
module ram_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1    // legal range 1..4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ren_0,
    input  logic [ADDR_WIDTH-1:0] raddr_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic                  rvalid_0,
    input  logic                  wen_0,
    input  logic [ADDR_WIDTH-1:0] waddr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic                  debug_write_en,
    input  logic [ADDR_WIDTH-1:0] debug_write_addr,
    input  logic [DATA_WIDTH-1:0] debug_write_data,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    output logic [7:0]            collision_count,
    output logic                  range_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic r_in, w_in, dw_in, d_in;
    logic func_we, dbg_we;
    logic [DATA_WIDTH-1:0] rd_value;

    // Full-width unsigned compare: no wraparound onto low address bits.
    assign r_in  = raddr_0 < DEPTH_A;
    assign w_in  = waddr_0 < DEPTH_A;
    assign dw_in = debug_write_addr < DEPTH_A;
    assign d_in  = debug_addr < DEPTH_A;

    assign func_we = wen_0 & ~rst & w_in;
    assign dbg_we  = debug_write_en & dw_in;

    // No reset on the array: contents survive rst and debug preloads land during reset.
    always_ff @(posedge clk) begin
        if (func_we) mem[waddr_0[IDX_W-1:0]] <= wdata_0;
        if (dbg_we)  mem[debug_write_addr[IDX_W-1:0]] <= debug_write_data;
    end

    assign debug_data = d_in ? mem[debug_addr[IDX_W-1:0]] : '0;

    // Write-first at the issue edge; debug write overrides the functional one.
    always_comb begin
        rd_value = '0;
        if (r_in) begin
            rd_value = mem[raddr_0[IDX_W-1:0]];
            if (func_we && (waddr_0 == raddr_0))
                rd_value = wdata_0;
            if (dbg_we && (debug_write_addr == raddr_0))
                rd_value = debug_write_data;
        end
    end

    logic                  vld_chain  [READ_LATENCY+1];
    logic [DATA_WIDTH-1:0] data_chain [READ_LATENCY+1];

    assign vld_chain[0]  = ren_0;
    assign data_chain[0] = rd_value;

    // Each stage holds its data when idle, so the last stage gives rdata_0 its hold behaviour.
    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            logic                  vld_reg;
            logic [DATA_WIDTH-1:0] data_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_reg  <= 1'b0;
                    data_reg <= '0;
                end else begin
                    vld_reg <= vld_chain[gi];
                    if (vld_chain[gi])
                        data_reg <= data_chain[gi];
                end
            end

            assign vld_chain[gi+1]  = vld_reg;
            assign data_chain[gi+1] = data_reg;
        end
    endgenerate

    assign rvalid_0 = vld_chain[READ_LATENCY];
    assign rdata_0  = data_chain[READ_LATENCY];

    logic [7:0] collision_count_reg, collision_count_next;
    logic       range_err_reg, range_err_next;

    always_comb begin
        collision_count_next = collision_count_reg;
        range_err_next       = range_err_reg;
        if (func_we && dbg_we && (waddr_0 == debug_write_addr) && (collision_count_reg != 8'hFF))
            collision_count_next = collision_count_reg + 8'd1;
        if ((wen_0 && !w_in) || (ren_0 && !r_in) || (debug_write_en && !dw_in))
            range_err_next = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision_count_reg <= 8'd0;
            range_err_reg       <= 1'b0;
        end else begin
            collision_count_reg <= collision_count_next;
            range_err_reg       <= range_err_next;
        end
    end

    assign collision_count = collision_count_reg;
    assign range_err       = range_err_reg;

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the single-read/single-write RAM port bundle used by accelerator FSMs: `raddr_0`/`rdata_0` and `waddr_0`/`wen_0`/`wdata_0`.
- Adds a read-valid handshake, a configurable read pipeline and write-first forwarding.
- Has a debug preload/inspect port for benches, plus collision and range-error status.
- Sits between compute FSMs and the storage array; it is the responder end of the interface those FSMs initiate.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, address port width.
- DEPTH, 16, number of words. Valid addresses are 0..DEPTH-1.
- READ_LATENCY, 1, rising edges from read request to data visible. Legal range is 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ren_0  in  1  read request, sampled at the rising edge.
- raddr_0  in  ADDR_WIDTH  read address.
- rdata_0  out  DATA_WIDTH  read data.
- rvalid_0  out  1  rdata_0 holds the response to a request.
- wen_0  in  1  functional write enable.
- waddr_0  in  ADDR_WIDTH  functional write address.
- wdata_0  in  DATA_WIDTH  functional write data.
- debug_write_en  in  1  debug write enable.
- debug_write_addr  in  ADDR_WIDTH  debug write address.
- debug_write_data  in  DATA_WIDTH  debug write data.
- debug_addr  in  ADDR_WIDTH  debug read address.
- debug_data  out  DATA_WIDTH  combinational read of the array at debug_addr.
- collision_count  out  8  saturating count of same-address double writes.
- range_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - rst=1 immediately clears rdata_0=0, rvalid_0=0, all read-pipeline stages, collision_count=0 and range_err=0.
  - Array contents are NOT cleared and persist across reset.
- Debug writes commit at the rising edge even while rst=1, so benches can preload during reset.
- Functional ports (ren_0, wen_0) are ignored while rst=1.
- Reset asserted mid-read flushes all in-flight responses; no late rvalid_0 may appear after rst deasserts.
- Writes (synchronous, rising edge):
  - wen_0 and debug_write_en may both be active in one cycle.
  - Different addresses: both commit.
  - Same address: debug data wins and collision_count increments, saturating at 255.
- Read timing: ren_0=1 at edge k issues a request. rdata_0/rvalid_0 are updated at edge k+READ_LATENCY-1.
  - READ_LATENCY=1: response visible immediately after edge k.
  - rvalid_0 is high for exactly one cycle per request; rdata_0 holds its value otherwise.
  - Back-to-back requests on consecutive edges produce back-to-back responses, full throughput, in order.
- Read data source: the array is sampled at the issue edge (edge k), then carried down the pipeline.
  - Write-first forwarding applies at the issue edge only. If a write to the same address commits at edge k, the response carries the post-write value, applying the debug-over-functional priority above.
  - Writes at later edges do not alter an in-flight response.
- Range: any address >= DEPTH is out of range, on any port. No wraparound or modulo.
  - An out-of-range write is dropped and sets range_err.
  - An out-of-range read still responds, with rvalid_0=1 and rdata_0=0, and sets range_err.
  - debug_addr out of range gives debug_data=0 and does not set range_err.
  - range_err clears only on rst.
- debug_data is combinational from the array: it reflects a write in the cycle after the write edge.
- Width rules:
  - Address compare is unsigned on the full ADDR_WIDTH.
  - Data is stored and returned unmodified.
  - collision_count never wraps.

Test Plan:
1. Preload and retention: with rst=1, debug write addr 10=15 and one edge. Then deassert rst → debug_addr=10 gives 15. Pulse rst again → debug_data still 15, rdata_0=0, rvalid_0=0.
2. Read latency, READ_LATENCY=1 then 3: ren_0=1, raddr_0=10 for one edge k → rdata_0=15 with rvalid_0=1 for exactly one cycle after edge k (L=1) or after edge k+2 (L=3). rvalid_0=0 before and after.
3. Forwarding and a read-modify-write flow: at edge k write wen_0 addr 12=17 and read addr 12 → response 17. Read 10 (15), add 2, write 12 → debug_addr=12 gives 17.
4. Collision: same edge, wen_0 addr 5=1 and debug write addr 5=9 → mem[5]=9, collision_count=1. Different addresses 5 and 6 → both written, count unchanged. 300 collisions → count=255.
5. Range: DEPTH=16; write addr 16=7 → no array change, range_err=1. Read addr 20 → rvalid_0=1, rdata_0=0. range_err stays 1 until rst.
6. Reset mid-read, READ_LATENCY=3: issue reads on 3 consecutive edges, assert rst between edges → rvalid_0 drops at once. After deassert, no rvalid_0 for at least 4 edges without a new request.
